// File: rtl/rng_request_arbiter.sv
// Round-robin sharing of one 16-bit random stream among N_REQ requesters; each result is bounded to [0, limit].
// Accepted draws are masked to the limit's bit width; if none is accepted after MAX_TRIES draws, the last one is folded back into range.
module rng_request_arbiter #(
  parameter int N_REQ     = 4,
  parameter int MAX_TRIES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [15:0]          rnd_in,
  input  logic [N_REQ-1:0]     req,
  input  logic [16*N_REQ-1:0]  limit,
  output logic [N_REQ-1:0]     ack,
  output logic [15:0]          rnd_out,
  output logic                 busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   rr_ptr, rr_nx;
  logic [IW-1:0]   idx, idx_nx;
  logic [15:0]     lim_q, lim_nx;
  logic [15:0]     mask_q, mask_nx;
  logic [3:0]      try_cnt, try_nx;
  logic [15:0]     rnd_nx;
  logic [N_REQ-1:0] ack_nx;

  logic            found;
  logic [IW-1:0]   pick;
  logic [15:0]     pick_lim;
  logic [15:0]     m;

  // Smallest power-of-two-minus-one covering v.
  function automatic logic [15:0] fill_mask(input logic [15:0] v);
    logic [15:0] f;
    f = v | (v >> 1);
    f = f | (f >> 2);
    f = f | (f >> 4);
    f = f | (f >> 8);
    return f;
  endfunction

  // Scan downward so the last hit is the first set bit at or after rr_ptr.
  always_comb begin
    int j;
    j     = 0;
    found = 1'b0;
    pick  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = (int'(rr_ptr) + k) % N_REQ;
      if (req[j]) begin
        found = 1'b1;
        pick  = IW'(j);
      end
    end
  end

  assign pick_lim = limit[16*pick +: 16];
  assign m        = rnd_in & mask_q;
  assign busy     = (state != IDLE);

  always_comb begin
    state_nx = state;
    rr_nx    = rr_ptr;
    idx_nx   = idx;
    lim_nx   = lim_q;
    mask_nx  = mask_q;
    try_nx   = try_cnt;
    rnd_nx   = rnd_out;
    ack_nx   = '0;
    case (state)
      IDLE: begin
        if (found) begin
          idx_nx   = pick;
          lim_nx   = pick_lim;
          mask_nx  = fill_mask(pick_lim);
          try_nx   = 4'd0;
          rr_nx    = (pick == IW'(N_REQ - 1)) ? '0 : pick + 1'b1;
          state_nx = DRAW;
        end
      end
      DRAW: begin
        if (!req[idx]) begin
          state_nx = IDLE;
        end else if (m <= lim_q) begin
          rnd_nx      = m;
          ack_nx[idx] = 1'b1;
          state_nx    = DONE;
        end else if (try_cnt == 4'(MAX_TRIES - 1)) begin
          // m > lim_q here, and lim_q >= mask>>1, so the fold lands in range.
          rnd_nx      = m - lim_q - 16'd1;
          ack_nx[idx] = 1'b1;
          state_nx    = DONE;
        end else begin
          try_nx = try_cnt + 4'd1;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      idx     <= '0;
      lim_q   <= '0;
      mask_q  <= '0;
      try_cnt <= '0;
      rnd_out <= '0;
      ack     <= '0;
    end else begin
      state   <= state_nx;
      rr_ptr  <= rr_nx;
      idx     <= idx_nx;
      lim_q   <= lim_nx;
      mask_q  <= mask_nx;
      try_cnt <= try_nx;
      rnd_out <= rnd_nx;
      ack     <= ack_nx;
    end
  end

endmodule

// File: tb/tb_rng_request_arbiter.sv
// Scoreboard bench for rng_request_arbiter: expected (ack, value) pairs are queued when a request is driven.
module tb_rng_request_arbiter;
  localparam int N_REQ     = 4;
  localparam int MAX_TRIES = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic [15:0]         rnd_in;
  logic [N_REQ-1:0]    req;
  logic [16*N_REQ-1:0] limit;
  logic [N_REQ-1:0]    ack;
  logic [15:0]         rnd_out;
  logic                busy;

  rng_request_arbiter #(.N_REQ(N_REQ), .MAX_TRIES(MAX_TRIES)) dut (
    .clk     (clk),
    .reset   (reset),
    .rnd_in  (rnd_in),
    .req     (req),
    .limit   (limit),
    .ack     (ack),
    .rnd_out (rnd_out),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N_REQ-1:0] ack;
    logic [15:0]      val;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] rseq[8];
  int          rseq_n;
  logic        poke_en;
  logic [15:0] poke_val;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_lim(input int i, input logic [15:0] v);
    limit[16*i +: 16] = v;
  endtask

  task automatic push_exp(input logic [N_REQ-1:0] a, input logic [15:0] v);
    exp_t e;
    e.ack = a;
    e.val = v;
    sb.push_back(e);
  endtask

  // Result monitor: every ack cycle must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && ack != '0) begin
      if (sb.size() == 0) begin
        check_eq("unexp_ack", 32'(ack), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("sb_ack", 32'(ack), 32'(e.ack));
        check_eq("sb_rnd", 32'(rnd_out), 32'(e.val));
      end
    end
  end

  // Raise req, feed rseq one word per draw, drop req in the DONE cycle.
  task automatic serve(input logic [N_REQ-1:0] r, input int exp_edges, input string tag);
    int edges;
    int k;
    edges = 0;
    k     = 0;
    req   = r;
    @(posedge clk); #1;
    edges = 1;
    check_eq({tag, "_busy_draw"}, 32'(busy), 32'd1);
    if (poke_en) set_lim(0, poke_val);
    while (ack == '0 && edges < 40) begin
      rnd_in = rseq[(k < rseq_n) ? k : rseq_n - 1];
      k++;
      @(posedge clk); #1;
      edges++;
    end
    check_eq({tag, "_lat"}, 32'(edges), 32'(exp_edges));
    check_eq({tag, "_busy_done"}, 32'(busy), 32'd1);
    req    = '0;
    rnd_in = 16'($urandom);
    @(posedge clk); #1;
    check_eq({tag, "_idle"}, 32'({busy, ack}), 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    req      = '0;
    limit    = '0;
    rnd_in   = '0;
    poke_en  = 1'b0;
    poke_val = '0;
    rseq_n   = 1;
    for (int i = 0; i < 8; i++) rseq[i] = '0;
    #12;
    check_eq("rst_ack", 32'(ack), 32'd0);
    check_eq("rst_rnd", 32'(rnd_out), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // Single accept: mask 127, 0x42 & 127 = 66.
    set_lim(0, 16'd100);
    rseq[0] = 16'h0042;
    rseq_n  = 1;
    push_exp(4'b0001, 16'd66);
    serve(4'b0001, 2, "single");
    check_eq("single_hold", 32'(rnd_out), 32'd66);

    // Reset asserted mid-DRAW clears outputs without waiting for a clock edge.
    set_lim(1, 16'd100);
    req = 4'b0010;
    @(posedge clk); #1;
    rnd_in = 16'hFFFF;
    @(posedge clk); #1;
    check_eq("rstd_busy_pre", 32'(busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("rstd_ack", 32'(ack), 32'd0);
    check_eq("rstd_busy", 32'(busy), 32'd0);
    check_eq("rstd_rnd", 32'(rnd_out), 32'd0);
    req = '0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rstd_idle", 32'({busy, ack}), 32'd0);

    // Round robin from pointer 0, full-range limits pass rnd_in straight through.
    for (int i = 0; i < N_REQ; i++) set_lim(i, 16'hFFFF);
    for (int i = 0; i < 5; i++) begin
      rseq[0] = 16'hA000 + 16'(i * 16'h0111);
      rseq_n  = 1;
      push_exp(4'(1 << (i % N_REQ)), rseq[0]);
      serve(4'b1111, 2, "rr");
    end

    // Two rejects then accept; a limit change after grant must be ignored.
    set_lim(0, 16'd100);
    rseq[0]  = 16'h007F;
    rseq[1]  = 16'h0070;
    rseq[2]  = 16'h0010;
    rseq_n   = 3;
    poke_en  = 1'b1;
    poke_val = 16'hFFFF;
    push_exp(4'b0001, 16'd16);
    serve(4'b0001, 4, "reject");
    poke_en = 1'b0;

    // All draws rejected: fold 127 - 100 - 1.
    set_lim(0, 16'd100);
    rseq[0] = 16'hFFFF;
    rseq_n  = 1;
    push_exp(4'b0001, 16'd26);
    serve(4'b0001, 1 + MAX_TRIES, "fallback");

    // Abort: req1 dropped during DRAW while the next word would have been accepted.
    set_lim(1, 16'd100);
    req = 4'b0010;
    @(posedge clk); #1;
    rnd_in = 16'hFFFF;
    @(posedge clk); #1;
    check_eq("abort_busy_pre", 32'(busy), 32'd1);
    req    = '0;
    rnd_in = 16'h0010;
    @(posedge clk); #1;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_ack", 32'(ack), 32'd0);
    check_eq("abort_rnd", 32'(rnd_out), 32'd26);

    // limit 0 on requester 3 always yields 0.
    set_lim(3, 16'd0);
    rseq[0] = 16'hBEEF;
    rseq_n  = 1;
    push_exp(4'b1000, 16'd0);
    serve(4'b1000, 2, "lim0");

    repeat (3) @(posedge clk);
    #1;
    check_eq("sb_left", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rng_request_arbiter.md
Name: rng_request_arbiter

Overview:
Shares the free-running 16-bit pseudorandom source between up to N_REQ game-logic requesters (duck spawn X, flight direction, speed, and so on). Each requester asks for one value bounded to [0, limit]. The block picks requesters round-robin and reduces the raw random word into range. It sits between the RNG output and the game/peripheral logic that the CR16 program reads.

Parameters:
N_REQ, 4, number of requesters (2..8)
MAX_TRIES, 4, rejection-sampling draws before deterministic fallback (1..15)

Ports:
clk  input  1  global clock, rising edge
reset  input  1  asynchronous, active-high reset
rnd_in  input  16  raw random word from the generator; changes every clock
req  input  N_REQ  per-requester request level; held high until ack
limit  input  16*N_REQ  flattened inclusive upper bounds; requester i uses bits [16i+15:16i]
ack  output  N_REQ  one-hot, one-cycle pulse: value ready for that requester
rnd_out  output  16  bounded result; valid while ack is high, held until next ack
busy  output  1  high in DRAW and DONE

Behaviour:
- Reset, asynchronous: state=IDLE, ack=0, rnd_out=0, busy=0, rr_ptr=0, try_cnt=0, grant index=0.
- States: IDLE, DRAW, DONE.
- IDLE:
  - If any req bit is high, select the first set bit scanning upward from rr_ptr, wrapping modulo N_REQ.
  - Latch that index and its limit. Compute mask = limit with all bits below its MSB set (limit=0 gives mask=0).
  - Set try_cnt=0, set rr_ptr=index+1 mod N_REQ, go to DRAW.
  - With no req, stay in IDLE.
- DRAW, evaluated each edge: m = rnd_in & mask.
  - If m <= latched limit: rnd_out<=m, ack[index]<=1, go to DONE.
  - Else if try_cnt == MAX_TRIES-1: rnd_out<=m-limit-1, ack[index]<=1, go to DONE. This is always <= limit because limit >= mask>>1.
  - Else try_cnt++, stay in DRAW. The next cycle uses the new rnd_in.
  - If req[index] is low at the edge, abort: no ack, rnd_out unchanged, go to IDLE. Abort takes priority over acceptance.
- DONE: exactly one cycle with ack high. The next edge clears ack and returns to IDLE. The requester must drop req during the DONE cycle; req still high in the next IDLE cycle is a new request.
- Latency: req high before edge E gives a grant at E. The first sample is at E+1. In the best case ack is high for the cycle after E+1, so ack appears two edges after req.
- Worst case is 1+MAX_TRIES edges to ack.
- Throughput: at most one result per 3 cycles.
- limit is sampled only at grant. Changes to limit during DRAW are ignored.
- limit=0xFFFF: mask=0xFFFF, always accepted on the first draw, rnd_out=rnd_in.
- limit=0: mask=0, m=0, accepted on the first draw, rnd_out=0.
- Requesters that raise req during DRAW/DONE wait; no request is lost while it is held.
- Reset asserted mid-DRAW or mid-DONE: immediate return to reset values. Any pending ack is dropped.
- All arithmetic is 16-bit unsigned. The fallback subtraction cannot underflow because m > limit.

Test Plan:
- Reset mid-transfer: assert reset during DRAW -> ack=0, busy=0, rnd_out=0 asynchronously, before the next clk edge. After release with req=0, IDLE holds.
- Single requester accept: req=0001, limit0=100, rnd_in=0x0042 -> mask=127, m=66, ack=0001 for exactly one cycle two edges after req, rnd_out=66, busy high in DRAW and DONE.
- Rejection then accept: limit0=100, rnd_in sequence 0x007F, 0x0070, 0x0010 -> m=127 rejected, m=112 rejected, m=16 accepted; ack on the third draw, rnd_out=16.
- Fallback: MAX_TRIES=4, limit0=100, rnd_in held 0xFFFF -> four rejects, then rnd_out=127-100-1=26, ack asserted.
- Round-robin fairness: req=1111 held and re-raised after each DONE, all limits=0xFFFF -> ack order 0001,0010,0100,1000,0001. Each rnd_out equals rnd_in at that requester's DRAW edge.
- Abort and edges: req1 granted, then dropped during DRAW with rnd_in rejecting -> no ack, returns to IDLE, req3 then served. limit=0 gives rnd_out=0. limit=0xFFFF gives rnd_out=rnd_in.
